// File: rtl/fir_sequencer.sv
// 4-tap FIR sequencer that drives an external combinational arithmetic unit.
// Define FIR_SATURATE_EN to saturate the accumulator on add carry instead of wrapping.
module fir_sequencer #(
    parameter logic [7:0] C0 = 8'd1,
    parameter logic [7:0] C1 = 8'd2,
    parameter logic [7:0] C2 = 8'd3,
    parameter logic [7:0] C3 = 8'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] aluout,
    input  logic        zout,
    input  logic        cout,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        AaddB,
    output logic        AmulB,
    output logic        cin,
    output logic [15:0] y_out,
    output logic        y_valid,
    output logic        y_ovf,
    output logic        y_zero
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t      state;
    logic [1:0]  i;
    logic [7:0]  tap0, tap1, tap2, tap3;
    logic [15:0] prod;
    logic [15:0] acc;
    logic        ovf;
    logic [7:0]  tap_sel;
    logic [7:0]  coef_sel;
    logic [15:0] acc_next;

    // Tap and coefficient selected by the current tap index
    always_comb begin
        tap_sel  = tap0;
        coef_sel = C0;
        case (i)
            2'd0: begin tap_sel = tap0; coef_sel = C0; end
            2'd1: begin tap_sel = tap1; coef_sel = C1; end
            2'd2: begin tap_sel = tap2; coef_sel = C2; end
            2'd3: begin tap_sel = tap3; coef_sel = C3; end
            default: ;
        endcase
    end

    // Once saturated, the accumulator stays pinned for the rest of the sample
    always_comb begin
`ifdef FIR_SATURATE_EN
        acc_next = (cout || ovf) ? 16'hFFFF : aluout;
`else
        acc_next = aluout;
`endif
    end

    // Operation outputs decode from registered state only
    always_comb begin
        A     = 16'h0000;
        B     = 16'h0000;
        AaddB = 1'b0;
        AmulB = 1'b0;
        case (state)
            MUL: begin
                A     = {8'h00, tap_sel};
                B     = {8'h00, coef_sel};
                AmulB = 1'b1;
            end
            ADD: begin
                A     = acc;
                B     = prod;
                AaddB = 1'b1;
            end
            default: ;
        endcase
    end

    assign cin          = 1'b0;
    assign sample_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            i       <= 2'd0;
            tap0    <= 8'h00;
            tap1    <= 8'h00;
            tap2    <= 8'h00;
            tap3    <= 8'h00;
            prod    <= 16'h0000;
            acc     <= 16'h0000;
            ovf     <= 1'b0;
            y_out   <= 16'h0000;
            y_valid <= 1'b0;
            y_ovf   <= 1'b0;
            y_zero  <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        tap3  <= tap2;
                        tap2  <= tap1;
                        tap1  <= tap0;
                        tap0  <= sample_in;
                        acc   <= 16'h0000;
                        ovf   <= 1'b0;
                        i     <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod  <= aluout;
                    state <= ADD;
                end
                ADD: begin
                    acc <= acc_next;
                    ovf <= ovf | cout;
                    if (i == 2'd3) begin
                        y_out   <= acc_next;
                        y_ovf   <= ovf | cout;
                        y_zero  <= zout;
                        y_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        i     <= i + 2'd1;
                        state <= MUL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
